// File: rtl/softreg_initiator_pkg.sv
// SoftReg channel payload types shared by the initiator and its responders.
package softreg_initiator_pkg;

   localparam int unsigned SR_ADDR_W = 32;
   localparam int unsigned SR_DATA_W = 64;
   localparam int unsigned SR_OUT_W  = 8;

   typedef struct packed {
      logic                 valid;
      logic                 is_write;
      logic [SR_ADDR_W-1:0] addr;
      logic [SR_DATA_W-1:0] data;
   } softreg_req_t;

   typedef struct packed {
      logic                 valid;
      logic [SR_DATA_W-1:0] data;
   } softreg_resp_t;

endpackage

// File: rtl/softreg_initiator.sv
// SoftReg master: turns a command stream into SoftRegReq transactions, returns read data,
// tracks outstanding reads, abandons them on timeout and flags spurious responses.
module softreg_initiator
   import softreg_initiator_pkg::*;
#(
   parameter int unsigned MAX_OUTSTANDING = 4,
   parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_cmd_valid,
   output logic                 o_cmd_ready_c,
   input  logic                 i_cmd_is_write,
   input  logic [SR_ADDR_W-1:0] i_cmd_addr,
   input  logic [SR_DATA_W-1:0] i_cmd_data,
   output softreg_req_t         o_softreg_req,
   input  logic                 i_softreg_req_grant,
   input  softreg_resp_t        i_softreg_resp,
   output logic                 o_softreg_resp_grant_c,
   output logic                 o_rd_valid,
   output logic [SR_DATA_W-1:0] o_rd_data,
   input  logic                 i_rd_ready,
   output logic [SR_OUT_W-1:0]  o_outstanding,
   output logic                 o_err_timeout,
   output logic                 o_err_spurious,
   input  logic                 i_err_clear
);

   localparam int unsigned      TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic             TO_EN   = (TIMEOUT_CYCLES != 0);
   localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [SR_OUT_W-1:0] MAX_OUT = SR_OUT_W'(MAX_OUTSTANDING);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_ISSUE = 1'b1
   } state_t;

   state_t                r_state;
   softreg_req_t          r_req;
   logic [SR_OUT_W-1:0]   r_outstanding;
   logic [TO_W-1:0]       r_to_cnt;
   logic                  r_rd_valid;
   logic [SR_DATA_W-1:0]  r_rd_data;
   logic                  r_err_timeout;
   logic                  r_err_spurious;

   logic w_out_zero;
   logic w_accept;
   logic w_rd_grant;
   logic w_resp_load;
   logic w_resp_spur;
   logic w_timeout;

   // Writes never consume a read slot, so they bypass the outstanding limit.
   assign w_out_zero    = (r_outstanding == '0);
   assign o_cmd_ready_c = (r_state == ST_IDLE) & (i_cmd_is_write | (r_outstanding < MAX_OUT));
   assign w_accept      = i_cmd_valid & o_cmd_ready_c;
   assign w_rd_grant    = (r_state == ST_ISSUE) & i_softreg_req_grant & ~r_req.is_write;

   // A response with nothing pending is always drained so the responder never stalls.
   assign o_softreg_resp_grant_c = i_softreg_resp.valid & (w_out_zero | ~r_rd_valid | i_rd_ready);
   assign w_resp_load = o_softreg_resp_grant_c & ~w_out_zero;
   assign w_resp_spur = o_softreg_resp_grant_c & w_out_zero;
   assign w_timeout   = TO_EN & ~w_out_zero & ~o_softreg_resp_grant_c & (r_to_cnt == TO_LAST);

   // Request FSM: one transaction held stable from accept until the responder grants it.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_IDLE;
         r_req   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_state        <= ST_ISSUE;
                  r_req.valid    <= 1'b1;
                  r_req.is_write <= i_cmd_is_write;
                  r_req.addr     <= i_cmd_addr;
                  r_req.data     <= i_cmd_data;
               end
            end
            ST_ISSUE: begin
               if (i_softreg_req_grant) begin
                  r_state     <= ST_IDLE;
                  r_req.valid <= 1'b0;
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_req.valid <= 1'b0;
            end
         endcase
      end
   end

   // Outstanding-read count; a grant and an answer in the same cycle cancel out.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_outstanding <= '0;
      end else if (w_timeout) begin
         r_outstanding <= '0;
      end else if (w_rd_grant & ~w_resp_load) begin
         r_outstanding <= r_outstanding + SR_OUT_W'(1);
      end else if (~w_rd_grant & w_resp_load) begin
         r_outstanding <= r_outstanding - SR_OUT_W'(1);
      end
   end

   // Idle-response counter: only runs while reads are pending and nothing comes back.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_to_cnt <= '0;
      end else if (!TO_EN || w_out_zero || o_softreg_resp_grant_c || w_timeout) begin
         r_to_cnt <= '0;
      end else begin
         r_to_cnt <= r_to_cnt + TO_W'(1);
      end
   end

   // Read data holding register; a new load in the consume cycle keeps rd_valid high.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rd_valid <= 1'b0;
         r_rd_data  <= '0;
      end else if (w_resp_load) begin
         r_rd_valid <= 1'b1;
         r_rd_data  <= i_softreg_resp.data;
      end else if (i_rd_ready) begin
         r_rd_valid <= 1'b0;
      end
   end

   // Sticky error flags; a new event wins over a simultaneous clear.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_err_timeout  <= 1'b0;
         r_err_spurious <= 1'b0;
      end else begin
         r_err_timeout  <= w_timeout   | (r_err_timeout  & ~i_err_clear);
         r_err_spurious <= w_resp_spur | (r_err_spurious & ~i_err_clear);
      end
   end

   assign o_softreg_req  = r_req;
   assign o_outstanding  = r_outstanding;
   assign o_rd_valid     = r_rd_valid;
   assign o_rd_data      = r_rd_data;
   assign o_err_timeout  = r_err_timeout;
   assign o_err_spurious = r_err_spurious;

endmodule

// File: tb/tb_softreg_initiator.sv
// Self-checking bench for softreg_initiator: directed scenarios plus randomized traffic
// against a cycle-level behavioural model built from the channel rules.
module tb_softreg_initiator;
   import softreg_initiator_pkg::*;

   localparam int MAXO = 4;
   localparam int TMO  = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic          cmd_is_write = 1'b0;
   logic [31:0]   cmd_addr = '0;
   logic [63:0]   cmd_data = '0;
   softreg_req_t  req;
   logic          req_grant = 1'b0;
   softreg_resp_t resp = '0;
   logic          resp_grant;
   logic          rd_valid;
   logic [63:0]   rd_data;
   logic          rd_ready = 1'b0;
   logic [7:0]    outstanding;
   logic          err_to;
   logic          err_sp;
   logic          err_clear = 1'b0;

   int checks = 0;
   int passes = 0;

   softreg_initiator #(.MAX_OUTSTANDING(MAXO), .TIMEOUT_CYCLES(TMO)) dut (
      .i_clk                  (clk),
      .i_rst_n                (rst_n),
      .i_cmd_valid            (cmd_valid),
      .o_cmd_ready_c          (cmd_ready),
      .i_cmd_is_write         (cmd_is_write),
      .i_cmd_addr             (cmd_addr),
      .i_cmd_data             (cmd_data),
      .o_softreg_req          (req),
      .i_softreg_req_grant    (req_grant),
      .i_softreg_resp         (resp),
      .o_softreg_resp_grant_c (resp_grant),
      .o_rd_valid             (rd_valid),
      .o_rd_data              (rd_data),
      .i_rd_ready             (rd_ready),
      .o_outstanding          (outstanding),
      .o_err_timeout          (err_to),
      .o_err_spurious         (err_sp),
      .i_err_clear            (err_clear)
   );

   always #5 clk = ~clk;

   // Behavioural model of the channel, stepped once per clock.
   bit          m_pend;
   bit          m_wr;
   logic [31:0] m_addr;
   logic [63:0] m_data;
   int          m_out;
   int          m_cnt;
   bit          m_rdv;
   logic [63:0] m_rdd;
   bit          m_eto;
   bit          m_esp;

   function automatic bit m_cmd_ready();
      return !m_pend && (cmd_is_write || (m_out < MAXO));
   endfunction

   function automatic bit m_resp_grant();
      return resp.valid && ((m_out == 0) || !m_rdv || rd_ready);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_pend = 0; m_wr = 0; m_addr = '0; m_data = '0;
         m_out = 0; m_cnt = 0; m_rdv = 0; m_rdd = '0; m_eto = 0; m_esp = 0;
      end else begin
         bit acc, racc, good, spur, rdg, fire;
         acc  = cmd_valid && m_cmd_ready();
         racc = m_resp_grant();
         good = racc && (m_out > 0);
         spur = racc && (m_out == 0);
         rdg  = m_pend && req_grant && !m_wr;
         fire = (m_out > 0) && !racc && (m_cnt == TMO - 1);
         m_cnt = (racc || (m_out == 0) || fire) ? 0 : m_cnt + 1;
         m_out = fire ? 0 : m_out + (rdg ? 1 : 0) - (good ? 1 : 0);
         if (good) begin
            m_rdv = 1; m_rdd = resp.data;
         end else if (rd_ready) begin
            m_rdv = 0;
         end
         m_esp = spur || (m_esp && !err_clear);
         m_eto = fire || (m_eto && !err_clear);
         if (m_pend) begin
            if (req_grant) m_pend = 0;
         end else if (acc) begin
            m_pend = 1; m_wr = cmd_is_write; m_addr = cmd_addr; m_data = cmd_data;
         end
      end
   end

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      cmd_valid = 0; cmd_is_write = 0; req_grant = 0; resp = '0; rd_ready = 0; err_clear = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Offers one command and grants it on the first ISSUE cycle; grant is left high.
   task automatic issue(input bit w, input logic [31:0] a, input logic [63:0] d);
      @(negedge clk);
      cmd_valid = 1; cmd_is_write = w; cmd_addr = a; cmd_data = d; req_grant = 1;
      @(negedge clk);
      cmd_valid = 0;
   endtask

   task automatic test_reset();
      #2;
      checks++; if (req.valid !== 1'b0) $display("FAIL rst_req_valid got=%b want=0", req.valid); else passes++;
      checks++; if (rd_valid !== 1'b0) $display("FAIL rst_rd_valid got=%b want=0", rd_valid); else passes++;
      checks++; if (outstanding !== 8'd0) $display("FAIL rst_outstanding got=%0d want=0", outstanding); else passes++;
      checks++; if ({err_to, err_sp} !== 2'b00) $display("FAIL rst_errors got=%b want=00", {err_to, err_sp}); else passes++;
      checks++; if (resp_grant !== 1'b0) $display("FAIL rst_resp_grant got=%b want=0", resp_grant); else passes++;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #3;
      checks++; if (cmd_ready !== 1'b1) $display("FAIL rst_exit_cmd_ready got=%b want=1", cmd_ready); else passes++;
   endtask

   task automatic test_write();
      @(negedge clk);
      cmd_valid = 1; cmd_is_write = 1; cmd_addr = 32'h10; cmd_data = 64'h2A; req_grant = 0;
      #3;
      checks++; if (cmd_ready !== 1'b1) $display("FAIL wr_cmd_ready got=%b want=1", cmd_ready); else passes++;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         cmd_valid = 0; cmd_addr = 32'hFFFF; cmd_data = '1; req_grant = (i == 2);
         #3;
         checks++;
         if ({req.valid, req.is_write, req.addr, req.data} !== {1'b1, 1'b1, 32'h10, 64'h2A})
            $display("FAIL wr_hold%0d got=%h want=%h", i, {req.valid, req.is_write, req.addr, req.data},
                     {1'b1, 1'b1, 32'h10, 64'h2A});
         else passes++;
         checks++; if (cmd_ready !== 1'b0) $display("FAIL wr_busy_ready%0d got=%b want=0", i, cmd_ready); else passes++;
      end
      @(negedge clk);
      req_grant = 0;
      #3;
      checks++; if (req.valid !== 1'b0) $display("FAIL wr_done_valid got=%b want=0", req.valid); else passes++;
      checks++; if (outstanding !== 8'd0) $display("FAIL wr_outstanding got=%0d want=0", outstanding); else passes++;
   endtask

   task automatic test_read();
      @(negedge clk);
      cmd_valid = 1; cmd_is_write = 0; cmd_addr = 32'h8; req_grant = 0;
      @(negedge clk);
      cmd_valid = 0; req_grant = 1;
      #3;
      checks++;
      if ({req.valid, req.is_write, req.addr} !== {1'b1, 1'b0, 32'h8})
         $display("FAIL rd_req got=%h want=%h", {req.valid, req.is_write, req.addr}, {1'b1, 1'b0, 32'h8});
      else passes++;
      @(negedge clk);
      req_grant = 0;
      #3;
      checks++; if (outstanding !== 8'd1) $display("FAIL rd_out_inc got=%0d want=1", outstanding); else passes++;
      repeat (4) @(negedge clk);
      resp.valid = 1; resp.data = 64'hBEEF;
      #3;
      checks++; if (resp_grant !== 1'b1) $display("FAIL rd_resp_grant got=%b want=1", resp_grant); else passes++;
      @(negedge clk);
      resp = '0;
      #3;
      checks++;
      if ({rd_valid, rd_data} !== {1'b1, 64'hBEEF})
         $display("FAIL rd_data got=%b/%h want=1/beef", rd_valid, rd_data);
      else passes++;
      checks++; if (outstanding !== 8'd0) $display("FAIL rd_out_dec got=%0d want=0", outstanding); else passes++;
      @(negedge clk);
      rd_ready = 1;
      @(negedge clk);
      rd_ready = 0;
      #3;
      checks++; if (rd_valid !== 1'b0) $display("FAIL rd_consumed got=%b want=0", rd_valid); else passes++;
   endtask

   task automatic test_max_outstanding();
      apply_reset();
      for (int i = 0; i < 4; i++) issue(0, 32'h100 + 32'(i), '0);
      @(negedge clk);
      req_grant = 0; cmd_valid = 1; cmd_is_write = 0; cmd_addr = 32'h200;
      #3;
      checks++; if (cmd_ready !== 1'b0) $display("FAIL max_read_blocked got=%b want=0", cmd_ready); else passes++;
      checks++; if (outstanding !== 8'd4) $display("FAIL max_out got=%0d want=4", outstanding); else passes++;
      @(negedge clk);
      cmd_is_write = 1; cmd_addr = 32'h44; cmd_data = 64'h77;
      #3;
      checks++; if (cmd_ready !== 1'b1) $display("FAIL max_write_ok got=%b want=1", cmd_ready); else passes++;
      @(negedge clk);
      cmd_valid = 0; req_grant = 1;
      #3;
      checks++; if ({req.valid, req.is_write} !== 2'b11) $display("FAIL max_write_req got=%b want=11", {req.valid, req.is_write}); else passes++;
      @(negedge clk);
      req_grant = 0; cmd_valid = 1; cmd_is_write = 0; cmd_addr = 32'h50;
      resp.valid = 1; resp.data = 64'hD0;
      #3;
      checks++; if (cmd_ready !== 1'b0) $display("FAIL max_still_blocked got=%b want=0", cmd_ready); else passes++;
      checks++; if (outstanding !== 8'd4) $display("FAIL max_write_no_count got=%0d want=4", outstanding); else passes++;
      @(negedge clk);
      resp = '0;
      #3;
      checks++; if (outstanding !== 8'd3) $display("FAIL max_after_resp got=%0d want=3", outstanding); else passes++;
      checks++; if (cmd_ready !== 1'b1) $display("FAIL max_unblocked got=%b want=1", cmd_ready); else passes++;
      @(negedge clk);
      cmd_valid = 0; req_grant = 1;
      @(negedge clk);
      req_grant = 0;
      #3;
      checks++; if (outstanding !== 8'd4) $display("FAIL max_refill got=%0d want=4", outstanding); else passes++;
   endtask

   task automatic test_timeout();
      apply_reset();
      issue(0, 32'h30, '0);
      issue(0, 32'h31, '0);
      @(negedge clk);
      req_grant = 0;
      repeat (13) @(negedge clk);
      #3;
      checks++; if ({err_to, outstanding} !== {1'b0, 8'd2}) $display("FAIL to_before got=%b/%0d want=0/2", err_to, outstanding); else passes++;
      @(negedge clk);
      #3;
      checks++; if ({err_to, outstanding} !== {1'b1, 8'd0}) $display("FAIL to_fire got=%b/%0d want=1/0", err_to, outstanding); else passes++;
      @(negedge clk);
      resp.valid = 1; resp.data = 64'h55;
      #3;
      checks++; if (resp_grant !== 1'b1) $display("FAIL to_late_grant got=%b want=1", resp_grant); else passes++;
      @(negedge clk);
      resp = '0;
      #3;
      checks++; if ({err_sp, rd_valid} !== 2'b10) $display("FAIL to_spurious got=%b want=10", {err_sp, rd_valid}); else passes++;
      @(negedge clk);
      err_clear = 1; resp.valid = 1; resp.data = 64'h66;
      @(negedge clk);
      err_clear = 0; resp = '0;
      #3;
      checks++; if ({err_to, err_sp} !== 2'b01) $display("FAIL to_set_wins got=%b want=01", {err_to, err_sp}); else passes++;
      @(negedge clk);
      err_clear = 1;
      @(negedge clk);
      err_clear = 0;
      #3;
      checks++; if ({err_to, err_sp} !== 2'b00) $display("FAIL to_cleared got=%b want=00", {err_to, err_sp}); else passes++;
   endtask

   task automatic test_backpressure();
      apply_reset();
      issue(0, 32'h60, '0);
      issue(0, 32'h61, '0);
      @(negedge clk);
      req_grant = 0; rd_ready = 0; resp.valid = 1; resp.data = 64'h111;
      #3;
      checks++; if (resp_grant !== 1'b1) $display("FAIL bp_first_grant got=%b want=1", resp_grant); else passes++;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         resp.data = 64'h222;
         #3;
         checks++; if (resp_grant !== 1'b0) $display("FAIL bp_stall%0d got=%b want=0", i, resp_grant); else passes++;
         checks++; if ({rd_valid, rd_data} !== {1'b1, 64'h111}) $display("FAIL bp_hold%0d got=%b/%h want=1/111", i, rd_valid, rd_data); else passes++;
      end
      @(negedge clk);
      rd_ready = 1;
      #3;
      checks++; if (resp_grant !== 1'b1) $display("FAIL bp_release got=%b want=1", resp_grant); else passes++;
      @(negedge clk);
      resp = '0; rd_ready = 0;
      #3;
      checks++; if ({rd_valid, rd_data} !== {1'b1, 64'h222}) $display("FAIL bp_second got=%b/%h want=1/222", rd_valid, rd_data); else passes++;
      checks++; if (outstanding !== 8'd0) $display("FAIL bp_out got=%0d want=0", outstanding); else passes++;
      @(negedge clk);
      rd_ready = 1;
      @(negedge clk);
      rd_ready = 0;
      #3;
      checks++; if (rd_valid !== 1'b0) $display("FAIL bp_drained got=%b want=0", rd_valid); else passes++;
   endtask

   task automatic test_reset_mid_issue();
      apply_reset();
      @(negedge clk);
      resp.valid = 1; resp.data = 64'h99;
      @(negedge clk);
      resp = '0;
      issue(0, 32'h70, '0);
      @(negedge clk);
      req_grant = 0; cmd_valid = 1; cmd_is_write = 1; cmd_addr = 32'h71; cmd_data = 64'h5;
      @(negedge clk);
      cmd_valid = 0;
      #3;
      checks++; if ({req.valid, outstanding, err_sp} !== {1'b1, 8'd1, 1'b1}) $display("FAIL mid_pre got=%b/%0d/%b want=1/1/1", req.valid, outstanding, err_sp); else passes++;
      #1 rst_n = 1'b0;
      #1;
      checks++; if (req.valid !== 1'b0) $display("FAIL mid_req_drop got=%b want=0", req.valid); else passes++;
      checks++; if ({outstanding, err_to, err_sp, rd_valid} !== {8'd0, 3'b000}) $display("FAIL mid_clear got=%0d/%b%b%b want=0/000", outstanding, err_to, err_sp, rd_valid); else passes++;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #3;
      checks++; if (req.valid !== 1'b0) $display("FAIL mid_after got=%b want=0", req.valid); else passes++;
   endtask

   task automatic test_random();
      apply_reset();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         bit quiet;
         @(negedge clk);
         quiet = ((cyc % 300) >= 250);
         cmd_valid    = ($urandom_range(0, 9) < 6);
         cmd_is_write = ($urandom_range(0, 9) < 3);
         cmd_addr     = $urandom;
         cmd_data     = {$urandom, $urandom};
         req_grant    = ($urandom_range(0, 1) == 1);
         resp.valid   = !quiet && ($urandom_range(0, 9) < 3);
         resp.data    = {$urandom, $urandom};
         rd_ready     = ($urandom_range(0, 9) < 6);
         err_clear    = ($urandom_range(0, 31) == 0);
         #3;
         checks++;
         if ({cmd_ready, resp_grant} !== {m_cmd_ready(), m_resp_grant()})
            $display("FAIL rnd_handshake c%0d got=%b want=%b", cyc, {cmd_ready, resp_grant}, {m_cmd_ready(), m_resp_grant()});
         else passes++;
         checks++;
         if (req.valid !== m_pend || (m_pend && {req.is_write, req.addr, req.data} !== {m_wr, m_addr, m_data}))
            $display("FAIL rnd_req c%0d got=%h want=%h", cyc, {req.valid, req.is_write, req.addr, req.data}, {m_pend, m_wr, m_addr, m_data});
         else passes++;
         checks++;
         if (rd_valid !== m_rdv || (m_rdv && rd_data !== m_rdd))
            $display("FAIL rnd_rd c%0d got=%b/%h want=%b/%h", cyc, rd_valid, rd_data, m_rdv, m_rdd);
         else passes++;
         checks++;
         if ({outstanding, err_to, err_sp} !== {8'(m_out), m_eto, m_esp})
            $display("FAIL rnd_status c%0d got=%0d/%b%b want=%0d/%b%b", cyc, outstanding, err_to, err_sp, m_out, m_eto, m_esp);
         else passes++;
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_max_outstanding();
      test_timeout();
      test_backpressure();
      test_reset_mid_issue();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

endmodule
